// File: rtl/spi_regs_pkg.sv
// Shared definitions for the SPI register front end.
// Register map, frame size and receive FSM states.
package spi_regs_pkg;

    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

    localparam int FRAME_BITS = 16;
    localparam int CNT_W      = 5;

    typedef enum logic {
        IDLE,
        RECEIVE
    } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer with history flop and edge pulses.
// Edges are masked until the chain has refilled after reset.
module sync_edge_detect #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   warm_q;
    logic                   hist_q;
    logic                   armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
            warm_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_q[SYNC_STAGES-1];
            warm_q <= {warm_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // A pin level differing from RESET_VAL must not look like an edge.
    assign armed = warm_q[SYNC_STAGES];
    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = armed & level & ~hist_q;
    assign fall  = armed & ~level & hist_q;

endmodule

// File: rtl/spi_peripheral.sv
// Write-only SPI mode 0 slave holding the five PWM control registers.
// Frame: {write, addr[6:0], data[7:0]}, MSB first.
module spi_peripheral
    import spi_regs_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    localparam logic [6:0]       MAX_A   = 7'(MAX_ADDR);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(FRAME_BITS + 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic copi_lvl, copi_rise, copi_fall;
    logic ncs_lvl, ncs_rise, ncs_fall;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .din(sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_copi (
        .clk(clk), .rst(rst), .din(copi),
        .level(copi_lvl), .rise(copi_rise), .fall(copi_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ncs (
        .clk(clk), .rst(rst), .din(ncs),
        .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
    );

    state_t                state_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [6:0]            addr;
    logic                  commit;

    assign addr   = shift_q[14:8];
    assign commit = ncs_rise && (cnt_q == CNT_END)
                    && shift_q[15] && (addr <= MAX_A);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            shift_q         <= '0;
            cnt_q           <= '0;
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ncs_fall) begin
                        shift_q <= '0;
                        cnt_q   <= '0;
                        state_q <= RECEIVE;
                    end
                end
                RECEIVE: begin
                    if (ncs_rise) begin
                        state_q <= IDLE;
                        if (commit) begin
                            unique case (1'b1)
                                addr == ADDR_EN_OUT_7_0:  en_reg_out_7_0  <= shift_q[7:0];
                                addr == ADDR_EN_OUT_15_8: en_reg_out_15_8 <= shift_q[7:0];
                                addr == ADDR_EN_PWM_7_0:  en_reg_pwm_7_0  <= shift_q[7:0];
                                addr == ADDR_EN_PWM_15_8: en_reg_pwm_15_8 <= shift_q[7:0];
                                addr == ADDR_PWM_DUTY:    pwm_duty_cycle  <= shift_q[7:0];
                                default: ;
                            endcase
                        end
                    end else if (sclk_rise && !ncs_lvl) begin
                        shift_q <= {shift_q[FRAME_BITS-2:0], copi_lvl};
                        if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed and random SPI write frames against a register-map model.
// Outputs are sampled 1ns after the rising clock edge.
module tb_spi_peripheral;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] r0, r1, r2, r3, r4;

    int vectors    = 0;
    int miscompares = 0;
    logic [7:0] model [5];

    always #5 clk = ~clk;

    spi_peripheral dut (
        .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
        .en_reg_out_7_0(r0), .en_reg_out_15_8(r1),
        .en_reg_pwm_7_0(r2), .en_reg_pwm_15_8(r3),
        .pwm_duty_cycle(r4)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_7_0"},  r0, model[0]);
        chk({tag, ".out_15_8"}, r1, model[1]);
        chk({tag, ".pwm_7_0"},  r2, model[2]);
        chk({tag, ".pwm_15_8"}, r3, model[3]);
        chk({tag, ".duty"},     r4, model[4]);
    endtask

    // Write lands only for a complete 16-bit write frame to a mapped address.
    task automatic model_apply(input logic [16:0] f, input int nbits);
        int a;
        a = int'(f[14:8]);
        if (nbits == 16 && f[15] && a <= 4) model[a] = f[7:0];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
    endtask

    task automatic shift_bits(input logic [16:0] f, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = f[i];
            tick(3);
            sclk = 1'b1;
            tick(3);
            sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [16:0] f, input int nbits, input bit do_fall);
        if (do_fall) ncs = 1'b0;
        tick(4);
        shift_bits(f, nbits);
        tick(3);
        ncs  = 1'b1;
        copi = 1'b0;
    endtask

    task automatic frame_and_check(input string tag, input logic [16:0] f, input int nbits);
        send_frame(f, nbits, 1'b1);
        model_apply(f, nbits);
        repeat (3) @(posedge clk);
        #1;
        check_all(tag);
        tick(2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        model_clear();
        tick(2);
    endtask

    initial begin
        logic [16:0] f;
        int          nb;
        rst  = 1'b1;
        sclk = 1'b0;
        copi = 1'b0;
        ncs  = 1'b1;
        model_clear();
        tick(3);
        #1;
        check_all("reset");
        do_reset();
        tick(4);

        // First write with exact latency from nCS rise at the pin.
        send_frame(17'h080F0, 16, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("latency_early", r0, 8'h00);
        @(posedge clk);
        #1;
        model_apply(17'h080F0, 16);
        check_all("first_write");
        tick(2);

        frame_and_check("b2b_duty", 17'h08455, 16);
        frame_and_check("b2b_pwm_hi", 17'h083AA, 16);
        frame_and_check("b2b_pwm_lo", 17'h08201, 16);

        frame_and_check("read_frame", 17'h004FF, 16);
        frame_and_check("bad_addr", 17'h085FF, 16);

        frame_and_check("short15", 17'h0813C >> 1, 15);
        frame_and_check("long17", 17'h0813C, 17);
        frame_and_check("good_813c", 17'h0813C, 16);

        // Reset in the middle of a frame, then nCS released quietly.
        ncs = 1'b0;
        tick(4);
        shift_bits(17'h080FF >> 8, 8);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        model_clear();
        tick(5);
        ncs = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_all("mid_reset");
        tick(4);
        frame_and_check("after_reset", 17'h08299, 16);

        // nCS already low when reset releases: no frame may start.
        ncs = 1'b0;
        tick(2);
        do_reset();
        send_frame(17'h0807E, 16, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check_all("ncs_low_reset");
        tick(4);

        for (int k = 0; k < 30; k++) begin
            int sel;
            sel = int'($urandom_range(0, 5));
            nb  = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
            f[15]    = ($urandom_range(0, 3) != 0);
            f[14:8]  = 7'($urandom_range(0, 7));
            f[7:0]   = 8'($urandom);
            f[16]    = 1'($urandom);
            if (nb == 15) f = f >> 1;
            if (nb == 16) f[16] = 1'b0;
            frame_and_check($sformatf("rand%0d", k), f, nb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
SPI-slave register front end that receives write frames from an off-chip controller and holds the five control registers consumed by pwm_peripheral: en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle. It sits directly upstream of pwm_peripheral inside the top-level tt_um wrapper. SCLK, COPI and nCS arrive on ui_in[0], ui_in[1] and ui_in[2] and are asynchronous to clk. Operation is write-only, SPI mode 0, MSB first.

Parameters:
SYNC_STAGES, 2, flops per input synchronizer (minimum 2).
MAX_ADDR, 4, highest valid register address; writes above it are dropped.

Ports:
clk  input  1  system clock, the only clock.
rst  input  1  synchronous, active-high reset; the top level drives it from ~rst_n.
sclk  input  1  SPI serial clock, asynchronous.
copi  input  1  SPI controller-out/peripheral-in data, asynchronous.
ncs  input  1  SPI chip select, active low, asynchronous.
en_reg_out_7_0  output  8  register 0x00.
en_reg_out_15_8  output  8  register 0x01.
en_reg_pwm_7_0  output  8  register 0x02.
en_reg_pwm_15_8  output  8  register 0x03.
pwm_duty_cycle  output  8  register 0x04.

Behaviour:
- Reset (rst=1 at a clk edge): all five registers go to 0x00, shift register to 0, bit counter to 0, FSM to IDLE. Synchronizer flops reset to sclk=0, copi=0, ncs=1 so that no edge is detected when reset is released.
- Synchronization: each input passes through SYNC_STAGES flops, then one history flop. Edges are (sync & ~hist) for rising and (~sync & hist) for falling. Only synchronized values are used downstream.
- Timing constraint: SCLK high and low phases are each at least 3 clk periods. nCS setup to the first SCLK rise and hold after the last SCLK rise are each at least 3 clk periods.
- Frame format, 16 bits, MSB first: bit15 = R/W (1=write), bits14:8 = address[6:0], bits7:0 = data.
- FSM states:
  - IDLE: on nCS falling edge, clear the counter and shift register and go to RECEIVE. If nCS is low at reset release with no falling edge seen, stay in IDLE. A mid-frame startup is never accepted.
  - RECEIVE: on each SCLK rising edge while synced nCS=0, shift = {shift[14:0], copi_sync} and counter += 1. The counter saturates at 17. SCLK falling edges are ignored. On nCS rising edge, go to IDLE and evaluate the commit.
- Commit rule, evaluated on the nCS rising edge: write only if counter==16 AND bit15==1 AND address<=MAX_ADDR. The addressed register takes data on that same clk edge. Otherwise nothing changes: short frame, long frame, read frame or bad address.
- Latency: register output updates SYNC_STAGES+1 clk edges after nCS rises at the pin (3 with the default). It is stable thereafter until the next valid write.
- Simultaneous events: an SCLK rising edge detected in the same cycle as the nCS rising edge is not shifted. An nCS falling edge in the same cycle as an SCLK edge starts the frame, and the SCLK edge is ignored.
- rst asserted mid-frame aborts the frame, with no partial write, and clears all registers.
- Registers are independent: a write touches exactly one register.

Decomposition:
- Package spi_regs_pkg:
  - ADDR_EN_OUT_7_0=7'h00, ADDR_EN_OUT_15_8=7'h01, ADDR_EN_PWM_7_0=7'h02, ADDR_EN_PWM_15_8=7'h03, ADDR_PWM_DUTY=7'h04.
  - FRAME_BITS=16.
  - FSM state enum {IDLE, RECEIVE}.
- One sub-module, sync_edge_detect (params SYNC_STAGES, RESET_VAL). Outputs: synced level, rise pulse, fall pulse. Instantiated three times.

Test Plan:
- Reset, then frame 0x80F0 (write, addr 0x00, data 0xF0) -> en_reg_out_7_0=0xF0 exactly 3 clk edges after the pin nCS rises; the other four registers stay 0x00.
- Back-to-back writes 0x8455, 0x83AA, 0x8201 -> pwm_duty_cycle=0x55, en_reg_pwm_15_8=0xAA, en_reg_pwm_7_0=0x01; en_reg_out_* unchanged.
- Read frame 0x04FF, then invalid-address write 0x85FF -> all registers keep their prior values.
- 15-bit frame, and separately 17-bit frame, targeting 0x01 with data 0x3C -> en_reg_out_15_8 unchanged; the following correct 16-bit write 0x813C -> 0x3C.
- rst pulsed after 8 SCLK rises of 0x80FF -> all registers 0x00. nCS released with no further edges -> no write. Next full frame writes normally.
- nCS held low across reset release, then 16 SCLKs of 0x807E and nCS rises -> no write, because no falling edge was seen.
